mem_access_unit: RTL and testbench

- MEM-stage data-memory access engine of the 5-stage MIPS pipeline. Sits between the EX/ME pipeline register and the ME/WB pipeline register.
- Converts load/store requests (byte/half/word, signed/unsigned) into a word-aligned req/ack data-bus transaction with byte enables.
- Stalls the pipeline until the bus completes, then presents the sign/zero-extended load data for ME/WB capture.
- Flags misaligned accesses and bus timeouts.

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/mem_load_align.sv | 35 +++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path:
// access-size encodings, FSM states and the alignment rule.
package mips_mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // The reserved size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      default:  return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the addressed byte/half lane out of a bus word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module mem_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);
  import mips_mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    byte_sel = rdata_i[7:0];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;

    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase

    case (size_i)
      MEM_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      MEM_HALF: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access engine: turns a load/store into one req/ack bus transaction,
// stalls the pipeline until it completes, and returns formatted load data.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] write_data_in,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_be_out,
  input  logic [31:0] bus_rdata_in,
  input  logic        bus_ack_in,
  output logic        stall_out,
  output logic [31:0] read_data_out,
  output logic        read_valid_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);
  import mips_mem_pkg::*;

  state_e      state_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] read_data_q;
  logic        read_valid_q;
  logic        bus_error_q;

  logic        access;
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] load_fmt;

  assign access     = mem_write_in | mem_read_in;
  assign misaligned = is_misaligned(mem_size_in, addr_in[1:0]);

  // Store lane steering; loads read the whole word with no write data.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = '0;
    if (mem_write_in) begin
      case (mem_size_in)
        MEM_BYTE: begin
          be_d    = 4'b0001 << addr_in[1:0];
          wdata_d = {4{write_data_in[7:0]}};
        end
        MEM_HALF: begin
          be_d    = addr_in[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{write_data_in[15:0]}};
        end
        default: wdata_d = write_data_in;
      endcase
    end
  end

  mem_load_align u_load_align (
    .rdata_i   (bus_rdata_in),
    .addr_lo_i (off_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .data_o    (load_fmt)
  );

  always_comb begin
    stall_out      = 1'b0;
    misaligned_out = 1'b0;
    case (state_q)
      IDLE: begin
        stall_out      = access & ~misaligned;
        misaligned_out = access & misaligned;
      end
      BUSY:    stall_out = 1'b1;
      default: stall_out = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      size_q       <= MEM_BYTE;
      off_q        <= '0;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      read_valid_q <= 1'b0;
      bus_error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access && !misaligned) begin
            size_q      <= mem_size_in;
            off_q       <= addr_in[1:0];
            uns_q       <= mem_unsigned_in;
            cnt_q       <= '0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_write_in;
            bus_addr_q  <= {addr_in[31:2], 2'b00};
            bus_be_q    <= be_d;
            bus_wdata_q <= wdata_d;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ack_in) begin
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              read_data_q  <= load_fmt;
              read_valid_q <= 1'b1;
            end
            state_q <= DONE;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            bus_req_q   <= 1'b0;
            bus_error_q <= 1'b1;
            read_data_q <= '0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        // The finished instruction's inputs are still present here; ignore them.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req_out    = bus_req_q;
  assign bus_we_out     = bus_we_q;
  assign bus_addr_out   = bus_addr_q;
  assign bus_wdata_out  = bus_wdata_q;
  assign bus_be_out     = bus_be_q;
  assign read_data_out  = read_data_q;
  assign read_valid_out = read_valid_q;
  assign bus_error_out  = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misaligned accesses,
// bus timeout and mid-transaction reset, with a load-data scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_in, mem_write_in, mem_unsigned_in;
  logic [1:0]  mem_size_in;
  logic [31:0] addr_in, write_data_in;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out, bus_rdata_in;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in;
  logic        stall_out, read_valid_out, misaligned_out, bus_error_out;
  logic [31:0] read_data_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .mem_size_in    (mem_size_in),
    .mem_unsigned_in(mem_unsigned_in),
    .addr_in        (addr_in),
    .write_data_in  (write_data_in),
    .bus_req_out    (bus_req_out),
    .bus_we_out     (bus_we_out),
    .bus_addr_out   (bus_addr_out),
    .bus_wdata_out  (bus_wdata_out),
    .bus_be_out     (bus_be_out),
    .bus_rdata_in   (bus_rdata_in),
    .bus_ack_in     (bus_ack_in),
    .stall_out      (stall_out),
    .read_data_out  (read_data_out),
    .read_valid_out (read_valid_out),
    .misaligned_out (misaligned_out),
    .bus_error_out  (bus_error_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_size_in = 2'b00;
    mem_unsigned_in = 1'b0; addr_in = '0; write_data_in = '0;
  endtask

  // Present a request in IDLE and check the combinational handshake.
  task automatic drive_req(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic exp_stall, input logic exp_mis);
    @(negedge clk);
    mem_read_in = rd; mem_write_in = wr; mem_size_in = sz;
    mem_unsigned_in = uns; addr_in = a; write_data_in = wd;
    #1;
    check({tag, "_idle_stall"}, 32'(stall_out), 32'(exp_stall));
    check({tag, "_idle_mis"}, 32'(misaligned_out), 32'(exp_mis));
  endtask

  // Run a previously driven request through BUSY (ack after 'delay' wait cycles) and DONE.
  task automatic complete(input string tag, input int delay, input logic [31:0] rdata,
                          input logic is_load, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(posedge clk); #1;
    check({tag, "_busy_req"}, 32'(bus_req_out), 32'd1);
    check({tag, "_busy_stall"}, 32'(stall_out), 32'd1);
    check({tag, "_we"}, 32'(bus_we_out), 32'(!is_load));
    check({tag, "_addr"}, bus_addr_out, exp_addr);
    check({tag, "_be"}, 32'(bus_be_out), 32'(exp_be));
    check({tag, "_wdata"}, bus_wdata_out, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check({tag, "_wait_req"}, 32'(bus_req_out), 32'd1);
      check({tag, "_wait_addr"}, bus_addr_out, exp_addr);
    end
    bus_ack_in = 1'b1; bus_rdata_in = rdata;
    @(posedge clk); #1;
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    check({tag, "_done_stall"}, 32'(stall_out), 32'd0);
    check({tag, "_done_req"}, 32'(bus_req_out), 32'd0);
    check({tag, "_done_valid"}, 32'(read_valid_out), 32'(is_load));
    if (read_valid_out && exp_q.size() > 0)
      check({tag, "_rdata"}, read_data_out, exp_q.pop_front());
    clear_req();
    @(posedge clk); #1;
    check({tag, "_after_valid"}, 32'(read_valid_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0; bus_ack_in = 1'b0; bus_rdata_in = '0;
    clear_req();
    #12;
    check("rst_req", 32'(bus_req_out), 32'd0);
    check("rst_be", 32'(bus_be_out), 32'd0);
    check("rst_rdata", read_data_out, 32'd0);
    check("rst_valid", 32'(read_valid_out), 32'd0);
    check("rst_err", 32'(bus_error_out), 32'd0);
    @(negedge clk); reset = 1'b1;

    // lw, immediate ack
    exp_q.push_back(32'hDEADBEEF);
    drive_req("lw", 1, 0, 2'b10, 0, 32'h100, 0, 1, 0);
    complete("lw", 0, 32'hDEADBEEF, 1, 32'h100, 4'b1111, 32'h0);

    // byte/half loads with extension
    exp_q.push_back(32'hFFFFFF80);
    drive_req("lb", 1, 0, 2'b00, 0, 32'h203, 0, 1, 0);
    complete("lb", 0, 32'h80FF_0000, 1, 32'h200, 4'b1111, 32'h0);
    exp_q.push_back(32'h00000080);
    drive_req("lbu", 1, 0, 2'b00, 1, 32'h203, 0, 1, 0);
    complete("lbu", 1, 32'h80FF_0000, 1, 32'h200, 4'b1111, 32'h0);
    exp_q.push_back(32'hFFFF80FF);
    drive_req("lh", 1, 0, 2'b01, 0, 32'h202, 0, 1, 0);
    complete("lh", 2, 32'h80FF_0000, 1, 32'h200, 4'b1111, 32'h0);

    // stores
    drive_req("sb", 0, 1, 2'b00, 0, 32'h301, 32'h0000_00AB, 1, 0);
    complete("sb", 0, 32'h0, 0, 32'h300, 4'b0010, 32'hABABABAB);
    drive_req("sh", 0, 1, 2'b01, 0, 32'h302, 32'h0000_1234, 1, 0);
    complete("sh", 1, 32'h0, 0, 32'h300, 4'b1100, 32'h12341234);

    // misaligned accesses: no stall, no request, load data untouched
    drive_req("mis_lw", 1, 0, 2'b10, 0, 32'h102, 0, 0, 1);
    @(posedge clk); #1;
    check("mis_lw_req", 32'(bus_req_out), 32'd0);
    check("mis_lw_rdata", read_data_out, 32'hFFFF80FF);
    drive_req("mis_lh", 1, 0, 2'b01, 0, 32'h101, 0, 0, 1);
    @(posedge clk); #1;
    check("mis_lh_req", 32'(bus_req_out), 32'd0);
    check("mis_lh_stall", 32'(stall_out), 32'd0);
    clear_req();

    // timeout: no ack ever
    drive_req("to", 1, 0, 2'b10, 0, 32'h400, 0, 1, 0);
    @(posedge clk); #1;
    check("to_hold_rdata", read_data_out, 32'hFFFF80FF);
    n = 0;
    while (bus_req_out && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("to_busy_cycles", 32'(n), 32'd16);
    check("to_err", 32'(bus_error_out), 32'd1);
    check("to_rdata", read_data_out, 32'd0);
    check("to_stall", 32'(stall_out), 32'd0);
    check("to_valid", 32'(read_valid_out), 32'd0);
    clear_req();
    @(posedge clk); #1;
    check("to_err_pulse", 32'(bus_error_out), 32'd0);

    // reset during BUSY, ack arrives late
    exp_q.push_back(32'h0000BEEF);
    drive_req("lw_seed", 1, 0, 2'b10, 0, 32'h500, 0, 1, 0);
    complete("lw_seed", 0, 32'h0000BEEF, 1, 32'h500, 4'b1111, 32'h0);
    drive_req("rst", 1, 0, 2'b10, 0, 32'h504, 0, 1, 0);
    @(posedge clk); #1;
    check("rst_busy_req", 32'(bus_req_out), 32'd1);
    reset = 1'b0;
    #1;
    check("rstb_req", 32'(bus_req_out), 32'd0);
    check("rstb_we", 32'(bus_we_out), 32'd0);
    check("rstb_addr", bus_addr_out, 32'd0);
    check("rstb_be", 32'(bus_be_out), 32'd0);
    check("rstb_rdata", read_data_out, 32'd0);
    clear_req();
    #1;
    check("rstb_stall", 32'(stall_out), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_ack_in = 1'b1; bus_rdata_in = 32'h12345678;
    @(posedge clk); #1;
    bus_ack_in = 1'b0; bus_rdata_in = '0;
    check("late_ack_valid", 32'(read_valid_out), 32'd0);
    check("late_ack_req", 32'(bus_req_out), 32'd0);
    check("late_ack_rdata", read_data_out, 32'd0);
    @(posedge clk); #1;
    check("late_ack_stall", 32'(stall_out), 32'd0);
    exp_q.push_back(32'hCAFEF00D);
    drive_req("lw_post", 1, 0, 2'b10, 0, 32'h600, 0, 1, 0);
    complete("lw_post", 0, 32'hCAFEF00D, 1, 32'h600, 4'b1111, 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
